// File: rtl/pong_ctrl_pkg.sv
// pong_ctrl_pkg: shared types, constants and helpers for the paddle position conditioner.
package pong_ctrl_pkg;
  typedef enum logic [1:0] {AXIS_Y, AXIS_X, AXIS_XINV, PADDLE} ctrl_mode_t;
  typedef enum logic {OWN_ANALOG, OWN_DIGITAL} owner_t;
  localparam logic [7:0] VPOS_CENTER = 8'h80;
  // Magnitude of a signed axis byte; -128 maps to 128.
  function automatic logic [7:0] abs8(input logic [7:0] a);
    return a[7] ? 8'(-a) : a;
  endfunction
  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return a >= b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/paddle_ctrl_if.sv
// paddle_ctrl_if: player input bus into the conditioner and position outputs to the core.
interface paddle_ctrl_if;
  logic        vsync;
  logic [1:0]  mode;
  logic [15:0] analog;
  logic [7:0]  paddle;
  logic        joy_up;
  logic        joy_down;
  logic [7:0]  vpos;
  logic        digital_owner;
  modport master(output vsync, mode, analog, paddle, joy_up, joy_down, input vpos, digital_owner);
  modport slave(input vsync, mode, analog, paddle, joy_up, joy_down, output vpos, digital_owner);
endinterface

// File: rtl/frame_tick.sv
// frame_tick: synchronises vsync and emits a registered one-cycle pulse per rising edge.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);
  logic [2:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '0;
      tick   <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], vsync};
      tick   <= r_sync[1] & ~r_sync[2];
    end
endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: per-frame paddle position from analog/paddle source or accelerated D-pad.
module paddle_ctrl
  import pong_ctrl_pkg::*;
#(
  parameter int DEADZONE     = 8,
  parameter int STEP_MIN     = 1,
  parameter int STEP_MAX     = 8,
  parameter int ACCEL_FRAMES = 4,
  parameter int SLEW         = 0
) (
  input logic          clk_sys,
  input logic          reset,
  paddle_ctrl_if.slave bus
);
  localparam logic [7:0] DZ   = 8'(DEADZONE);
  localparam logic [7:0] SMIN = 8'(STEP_MIN);
  localparam logic [7:0] SMAX = 8'(STEP_MAX);
  localparam logic [7:0] AF   = 8'(ACCEL_FRAMES);
  localparam logic [7:0] SL   = 8'(SLEW);
  logic       w_tick;
  ctrl_mode_t w_mode;
  owner_t     r_state, w_next;
  logic [7:0] r_vpos, r_pad_ref, r_step, r_hold;
  logic [1:0] r_mode_q;
  logic       r_dn;
  logic [7:0] w_axis, w_target, w_defl, w_step, w_hold, w_dig, w_slewed;
  logic [8:0] w_sum;
  logic       w_single, w_same, w_ret, w_mchg;
  frame_tick u_tick (.clk(clk_sys), .rst(reset), .vsync(bus.vsync), .tick(w_tick));
  always_comb begin
    w_mode   = ctrl_mode_t'(bus.mode);
    w_axis   = w_mode == AXIS_Y ? bus.analog[15:8] : bus.analog[7:0];
    w_target = w_mode == PADDLE ? bus.paddle : w_mode == AXIS_XINV ? w_axis ^ 8'h7F : w_axis + VPOS_CENTER;
    w_defl   = w_mode == PADDLE ? absdiff(bus.paddle, r_pad_ref) : abs8(w_axis);
    w_ret    = w_defl > DZ;
    w_mchg   = bus.mode != r_mode_q;
    w_single = bus.joy_up ^ bus.joy_down;
    // hold_cnt cycles 1..ACCEL_FRAMES while held; 0 means no direction was held last tick
    w_same   = w_single && r_hold != 8'd0 && bus.joy_down == r_dn;
    w_hold   = !w_single ? 8'd0 : (!w_same || r_hold == AF) ? 8'd1 : r_hold + 8'd1;
    w_step   = !w_same ? SMIN : (w_hold == AF && r_step < SMAX) ? r_step + 8'd1 : r_step;
    w_next   = w_single ? OWN_DIGITAL : (r_state == OWN_DIGITAL && w_ret) ? OWN_ANALOG : r_state;
    w_sum    = {1'b0, r_vpos} + {1'b0, w_step};
    w_dig    = !w_single ? r_vpos : bus.joy_down ? (w_sum[8] ? 8'hFF : w_sum[7:0]) :
               (r_vpos > w_step ? r_vpos - w_step : 8'd0);
    w_slewed = SLEW == 0 ? w_target :
               w_target > r_vpos ? (w_target - r_vpos > SL ? r_vpos + SL : w_target) :
               (r_vpos - w_target > SL ? r_vpos - SL : w_target);
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_state   <= OWN_ANALOG;
      r_vpos    <= VPOS_CENTER;
      r_step    <= SMIN;
      r_hold    <= 8'd0;
      r_pad_ref <= 8'd0;
      r_mode_q  <= 2'd0;
      r_dn      <= 1'b0;
    end else if (w_tick) begin
      r_mode_q <= bus.mode;
      r_dn     <= bus.joy_down;
      if (w_mchg) begin
        r_state <= OWN_ANALOG;
        r_vpos  <= w_target;
        r_step  <= SMIN;
        r_hold  <= 8'd0;
      end else begin
        r_state <= w_next;
        r_step  <= w_step;
        r_hold  <= w_hold;
        r_vpos  <= w_next == OWN_DIGITAL ? w_dig : w_slewed;
        if (r_state == OWN_ANALOG && w_next == OWN_DIGITAL) r_pad_ref <= bus.paddle;
      end
    end
  assign bus.vpos          = r_vpos;
  assign bus.digital_owner = r_state == OWN_DIGITAL;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: scoreboard bench for paddle_ctrl (default and SLEW=4 instances).
module tb_paddle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  paddle_ctrl_if ifa();
  paddle_ctrl_if ifb();
  paddle_ctrl u_dut (.clk_sys(clk), .reset(rst), .bus(ifa));
  paddle_ctrl #(.SLEW(4)) u_slew (.clk_sys(clk), .reset(rst), .bus(ifb));
  assign ifb.vsync    = ifa.vsync;
  assign ifb.mode     = ifa.mode;
  assign ifb.analog   = ifa.analog;
  assign ifb.paddle   = ifa.paddle;
  assign ifb.joy_up   = ifa.joy_up;
  assign ifb.joy_down = ifa.joy_down;
  typedef struct {bit sel; logic [7:0] v; bit o;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic vprev;
  logic [3:0] pipe;
  // Expected update strobe: vpos changes three edges after the edge that sees vsync rise
  always @(posedge clk or posedge rst)
    if (rst) begin
      vprev <= 1'b0;
      pipe  <= '0;
    end else begin
      vprev <= ifa.vsync;
      pipe  <= {pipe[2:0], ifa.vsync & ~vprev};
    end
  task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: vpos/owner got %h/%b want %h/%b", nm, act[8:1], act[0], exp[8:1], exp[0]);
    end
  endtask
  always @(negedge clk)
    if (pipe[3]) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame: update with empty expectation queue");
      end else begin
        e = q.pop_front();
        cmp(e.sel ? "frame_slew" : "frame", e.sel ? {ifb.vpos, ifb.digital_owner} : {ifa.vpos, ifa.digital_owner}, {e.v, e.o});
      end
    end
  task automatic frame(input bit sel, input logic [7:0] v, input bit o);
    q.push_back('{sel, v, o});
    ifa.vsync = 1'b1;
    repeat (3) @(negedge clk);
    ifa.vsync = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  initial begin
    int e;
    int st;
    ifa.vsync = 0; ifa.mode = 0; ifa.analog = 0; ifa.paddle = 0; ifa.joy_up = 0; ifa.joy_down = 0;
    repeat (3) @(negedge clk);
    cmp("reset", {ifa.vpos, ifa.digital_owner}, {8'h80, 1'b0});
    cmp("reset_slew", {ifb.vpos, ifb.digital_owner}, {8'h80, 1'b0});
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ifa.analog = 16'hC000;
    frame(0, 8'h40, 0);
    ifa.vsync = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 cmp("async_reset", {ifa.vpos, ifa.digital_owner}, {8'h80, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    q.push_back('{0, 8'h40, 0});
    repeat (8) @(negedge clk);
    ifa.vsync = 1'b0;
    repeat (5) @(negedge clk);
    ifa.analog = 16'h0000;
    frame(0, 8'h80, 0);
    ifa.joy_down = 1'b1;
    e = 8'h80;
    for (int k = 1; k <= 32; k++) begin
      st = 1 + k / 4;
      if (st > 8) st = 8;
      e = (e + st > 255) ? 255 : e + st;
      frame(0, 8'(e), 1);
    end
    ifa.joy_down = 1'b0;
    frame(0, 8'hFF, 1);
    ifa.mode = 2'd1;
    frame(0, 8'h80, 0);
    ifa.joy_down = 1'b1;
    frame(0, 8'h81, 1);
    ifa.joy_down = 1'b0;
    ifa.analog = 16'h0005;
    frame(0, 8'h81, 1);
    ifa.analog = 16'h0020;
    frame(0, 8'hA0, 0);
    ifa.mode = 2'd3;
    ifa.paddle = 8'h30;
    frame(0, 8'h30, 0);
    ifa.joy_up = 1'b1;
    frame(0, 8'h2F, 1);
    ifa.joy_up = 1'b0;
    ifa.paddle = 8'h37;
    frame(0, 8'h2F, 1);
    ifa.paddle = 8'h39;
    frame(0, 8'h39, 0);
    ifa.mode = 2'd0;
    ifa.analog = 16'h0000;
    frame(1, 8'h80, 0);
    ifa.analog = 16'h9000;
    for (int k = 1; k <= 28; k++) frame(1, 8'(8'h80 - 4 * k), 0);
    frame(1, 8'h10, 0);
    frame(0, 8'h10, 0);
    ifa.analog = 16'h7000;
    frame(1, 8'h14, 0);
    frame(1, 8'h18, 0);
    ifa.mode = 2'd1;
    ifa.analog = 16'h0040;
    frame(1, 8'hC0, 0);
    ifa.analog = 16'h0050;
    q.push_back('{0, 8'hD0, 0});
    ifa.vsync = 1'b1;
    repeat (4) @(negedge clk);
    ifa.analog = 16'h0010;
    repeat (56) @(negedge clk);
    cmp("vsync_held", {ifa.vpos, ifa.digital_owner}, {8'hD0, 1'b0});
    ifa.vsync = 1'b0;
    repeat (5) @(negedge clk);
    frame(0, 8'h90, 0);
    ifa.analog = 16'h0000;
    frame(0, 8'h80, 0);
    ifa.joy_down = 1'b1;
    frame(0, 8'h81, 1);
    frame(0, 8'h82, 1);
    frame(0, 8'h83, 1);
    frame(0, 8'h85, 1);
    ifa.joy_up = 1'b1;
    frame(0, 8'h85, 1);
    ifa.joy_up = 1'b0;
    frame(0, 8'h86, 1);
    frame(0, 8'h87, 1);
    frame(0, 8'h88, 1);
    frame(0, 8'h8A, 1);
    ifa.joy_down = 1'b0;
    ifa.joy_up = 1'b1;
    frame(0, 8'h89, 1);
    ifa.joy_up = 1'b0;
    frame(0, 8'h89, 1);
    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected updates never seen, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
